// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment word type, blank pattern and the
// active-high glyph table indexed by hex nibble (bit order {dp,g,f,e,d,c,b,a}).
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'h00;

    localparam seg_t FONT [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F,
        8'h66, 8'h6D, 8'h7D, 8'h27,
        8'h7F, 8'h6F, 8'h77, 8'h7C,
        8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/seg7_font.sv
// Combinational hex nibble to 7-segment glyph lookup (active-high, no dp).
module seg7_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = FONT[nibble][6:0];

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display driver: shadow/display double buffer committed at
// frame boundaries, per-slot guard time, leading-zero blanking, registered pins.
module hex_display_scan
    import seg7_pkg::*;
#(
    parameter int NDIGIT      = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int GUARD       = 2,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD,
    input  logic [4*NDIGIT-1:0]   VALUE,
    input  logic [NDIGIT-1:0]     DP,
    input  logic                  EN,
    output seg_t                  SEG,
    output logic [NDIGIT-1:0]     DIG,
    output logic                  FRAME,
    output logic                  PENDING
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIGIT - 1);
    localparam seg_t              SEG_IDLE = SEG_OFF ^ {8{ACTIVE_LOW}};
    localparam logic [NDIGIT-1:0] DIG_IDLE = {NDIGIT{ACTIVE_LOW}};

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                tick;
    logic                boundary;
    logic [4*NDIGIT-1:0] shadow_value;
    logic [NDIGIT-1:0]   shadow_dp;
    logic [4*NDIGIT-1:0] disp_value;
    logic [NDIGIT-1:0]   disp_dp;
    logic                pending;
    logic [NDIGIT-1:0]   blank;
    logic                zero_above;
    logic [3:0]          nibble;
    logic                dp_bit;
    logic [6:0]          glyph;
    seg_t                seg_act;
    logic [NDIGIT-1:0]   dig_act;
    seg_t                seg_p1;
    logic [NDIGIT-1:0]   dig_p1;
    logic                frame_p1;

    assign tick     = (cnt == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // A LOAD coinciding with the boundary wins over the commit's clear, so the
    // freshly captured value stays pending for the next frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            disp_value   <= '0;
            disp_dp      <= '0;
            pending      <= 1'b0;
            frame_p1     <= 1'b0;
        end else begin
            frame_p1 <= boundary;
            if (boundary && pending) begin
                disp_value <= shadow_value;
                disp_dp    <= shadow_dp;
            end
            if (LOAD) begin
                shadow_value <= VALUE;
                shadow_dp    <= DP;
                pending      <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NDIGIT - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_value[4*i +: 4] == 4'h0) && !disp_dp[i];
            if (i > 0) begin
                blank[i] = (LZ_SUPPRESS != 0) && zero_above;
            end
        end
    end

    assign nibble = disp_value[{idx, 2'b00} +: 4];
    assign dp_bit = disp_dp[idx];

    seg7_font u_font (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        seg_act = SEG_OFF;
        dig_act = '0;
        if (cnt >= GUARD_CNT && EN) begin
            dig_act[idx] = 1'b1;
            if (!blank[idx]) begin
                seg_act = {dp_bit, glyph};
            end
        end
    end

    // p1: pin registers, polarity applied here
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_p1 <= SEG_IDLE;
            dig_p1 <= DIG_IDLE;
        end else begin
            seg_p1 <= seg_act ^ {8{ACTIVE_LOW}};
            dig_p1 <= dig_act ^ {NDIGIT{ACTIVE_LOW}};
        end
    end

    assign SEG     = seg_p1;
    assign DIG     = dig_p1;
    assign FRAME   = frame_p1;
    assign PENDING = pending;

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench: stimulus queues per-frame expected glyphs; a monitor rebuilds
// each displayed frame from the pins and compares it when FRAME closes the frame.
module tb_hex_display_scan;

    typedef struct {
        int          frame;
        logic [31:0] seg;
        int          act;
        logic        pend;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LOAD;
    logic        EN;
    logic [15:0] VALUE;
    logic [3:0]  DP;
    logic [7:0]  seg_lo, seg_hi;
    logic [3:0]  dig_lo, dig_hi;
    logic        frame_lo, frame_hi, pend_lo, pend_hi;

    int   checks   = 0;
    int   failures = 0;
    int   frame_no = 0;
    exp_t q[$];

    hex_display_scan #(.NDIGIT(4), .SCAN_DIV(4), .GUARD(1), .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1)) u_dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .VALUE(VALUE), .DP(DP), .EN(EN),
        .SEG(seg_lo), .DIG(dig_lo), .FRAME(frame_lo), .PENDING(pend_lo)
    );

    hex_display_scan #(.NDIGIT(4), .SCAN_DIV(4), .GUARD(1), .ACTIVE_LOW(1'b0), .LZ_SUPPRESS(1)) u_dut_ah (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .VALUE(VALUE), .DP(DP), .EN(EN),
        .SEG(seg_hi), .DIG(dig_hi), .FRAME(frame_hi), .PENDING(pend_hi)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int fr, input logic [31:0] seg, input int act, input logic pend);
        exp_t e;
        e.frame = fr;
        e.seg   = seg;
        e.act   = act;
        e.pend  = pend;
        q.push_back(e);
    endtask

    task automatic wait_frame(output int n);
        int cycles;
        cycles = 0;
        do begin
            @(negedge CLK);
            cycles++;
        end while (!frame_lo && cycles < 100);
        check("frame_arrival", {31'd0, frame_lo}, 32'd1);
        n = frame_no;
    endtask

    task automatic load_value(input logic [15:0] v, input logic [3:0] d);
        LOAD  = 1'b1;
        VALUE = v;
        DP    = d;
        @(negedge CLK);
        LOAD  = 1'b0;
    endtask

    // Monitor: reconstructs both DUTs' frames from the pins.
    logic [7:0] rec_lo[4], rec_hi[4];
    int         cnt_lo[4], cnt_hi[4];
    int         cyc = 0;
    bit         have_prev = 1'b0;
    exp_t       e_cur;
    logic [3:0] inv_dig;
    logic [7:0] eb, eb_inv;

    task automatic clear_frame();
        for (int d = 0; d < 4; d++) begin
            rec_lo[d] = 8'h00;
            rec_hi[d] = 8'h00;
            cnt_lo[d] = 0;
            cnt_hi[d] = 0;
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (RST) begin
            clear_frame();
            have_prev = 1'b0;
            cyc = 0;
        end else begin
            cyc++;
            if (dig_lo != 4'hF) begin
                inv_dig = ~dig_lo;
                check("dig_onehot_lo", {31'd0, $onehot(inv_dig)}, 32'd1);
                for (int d = 0; d < 4; d++) if (!dig_lo[d]) begin
                    rec_lo[d] = seg_lo;
                    cnt_lo[d]++;
                end
            end else begin
                check("guard_seg_lo", {24'd0, seg_lo}, 32'hFF);
            end
            if (dig_hi != 4'h0) begin
                check("dig_onehot_hi", {31'd0, $onehot(dig_hi)}, 32'd1);
                for (int d = 0; d < 4; d++) if (dig_hi[d]) begin
                    rec_hi[d] = seg_hi;
                    cnt_hi[d]++;
                end
            end else begin
                check("guard_seg_hi", {24'd0, seg_hi}, 32'h00);
            end
            if (frame_lo) begin
                check("frame_ah", {31'd0, frame_hi}, 32'd1);
                if (have_prev) check($sformatf("frame_period_f%0d", frame_no), cyc, 32'd16);
                have_prev = 1'b1;
                cyc = 0;
                while (q.size() > 0 && q[0].frame < frame_no) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_missed actual=%0d required=%0d", frame_no, q[0].frame);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].frame == frame_no) begin
                    e_cur = q.pop_front();
                    check($sformatf("pending_end_f%0d", frame_no), {31'd0, pend_lo}, {31'd0, e_cur.pend});
                    check($sformatf("pending_end_ah_f%0d", frame_no), {31'd0, pend_hi}, {31'd0, e_cur.pend});
                    for (int d = 0; d < 4; d++) begin
                        eb     = e_cur.seg[8*d +: 8];
                        eb_inv = ~eb;
                        check($sformatf("active_lo_d%0d_f%0d", d, frame_no), cnt_lo[d], e_cur.act);
                        check($sformatf("active_hi_d%0d_f%0d", d, frame_no), cnt_hi[d], e_cur.act);
                        if (e_cur.act > 0) begin
                            check($sformatf("seg_lo_d%0d_f%0d", d, frame_no), {24'd0, rec_lo[d]}, {24'd0, eb});
                            check($sformatf("seg_hi_d%0d_f%0d", d, frame_no), {24'd0, rec_hi[d]}, {24'd0, eb_inv});
                        end
                    end
                end
                clear_frame();
                frame_no++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] cur;
        RST   = 1'b1;
        LOAD  = 1'b0;
        VALUE = 16'h0000;
        DP    = 4'h0;
        EN    = 1'b1;
        clear_frame();
        repeat (3) @(negedge CLK);
        check("reset_seg_lo", {24'd0, seg_lo}, 32'hFF);
        check("reset_dig_lo", {28'd0, dig_lo}, 32'hF);
        check("reset_seg_hi", {24'd0, seg_hi}, 32'h00);
        check("reset_dig_hi", {28'd0, dig_hi}, 32'h0);
        check("reset_pending", {31'd0, pend_lo}, 32'd0);
        check("reset_frame", {31'd0, frame_lo}, 32'd0);
        RST = 1'b0;

        // Power-up display of zero: only digit 0 lit.
        cur = 32'hFFFF_FFC0;
        push_exp(0, cur, 3, 1'b0);

        // 1234 loaded mid-frame: old content until the boundary.
        wait_frame(n);
        push_exp(n, cur, 3, 1'b0);
        load_value(16'h1234, 4'b0000);
        @(negedge CLK);
        check("pending_mid", {31'd0, pend_lo}, 32'd1);
        cur = 32'hF9A4_B099;

        // Leading zeros blanked above the 7.
        wait_frame(n);
        push_exp(n, cur, 3, 1'b0);
        load_value(16'h0070, 4'b0000);
        cur = 32'hFFFF_D8C0;

        // A decimal point stops zero suppression at its digit.
        wait_frame(n);
        push_exp(n, cur, 3, 1'b0);
        load_value(16'h0000, 4'b0100);
        cur = 32'hFF40_C0C0;

        // AAAA mid-frame, then BBBB exactly on the boundary tick.
        wait_frame(n);
        push_exp(n, cur, 3, 1'b1);
        push_exp(n + 1, 32'h8888_8888, 3, 1'b0);
        load_value(16'hAAAA, 4'b0000);
        repeat (14) @(negedge CLK);
        load_value(16'hBBBB, 4'b0000);
        check("boundary_frame", {31'd0, frame_lo}, 32'd1);
        cur = 32'h8383_8383;

        wait_frame(n);
        push_exp(n, cur, 3, 1'b0);

        // Display disabled for one whole frame; FRAME keeps its period.
        wait_frame(n);
        EN = 1'b0;
        push_exp(n, 32'h0, 0, 1'b0);
        wait_frame(n);
        EN = 1'b1;

        // Reset in the middle of a slot with data pending.
        load_value(16'h5555, 4'b0000);
        repeat (4) @(negedge CLK);
        check("pending_before_rst", {31'd0, pend_lo}, 32'd1);
        #2 RST = 1'b1;
        #1;
        check("rst_async_seg_lo", {24'd0, seg_lo}, 32'hFF);
        check("rst_async_dig_lo", {28'd0, dig_lo}, 32'hF);
        check("rst_async_seg_hi", {24'd0, seg_hi}, 32'h00);
        check("rst_async_dig_hi", {28'd0, dig_hi}, 32'h0);
        check("rst_async_pending", {31'd0, pend_lo}, 32'd0);
        check("rst_async_frame", {31'd0, frame_lo}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        push_exp(n, 32'hFFFF_FFC0, 3, 1'b0);
        wait_frame(n);
        check("scoreboard_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
